membank_write_ctrl: RTL and testbench

MEMBANK_WRITE_CTRL -- requirements
Module: membank_write_ctrl

---
 rtl/membank_write_ctrl.sv | 155 +++++++++++++++
 tb/tb_membank_write_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/membank_write_ctrl.sv
// Single-port memory bank controller: forcewrites, read-modify-write accumulates and reads.
// Optional macro MEMBANK_ACC_SATURATE_EN makes the accumulate saturate instead of wrapping.

package memory_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 16;

  typedef struct packed {
    logic                  en;
    logic                  forcewrite;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } write_req_pkt;
endpackage

module membank_write_ctrl
  import memory_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  write_req_pkt          write_req,
  output logic                  stall_front,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_stall,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int MEM_AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [MEM_AW-1:0]     acc_addr_q, acc_addr_d;
  logic [DATA_WIDTH-1:0] acc_data_q, acc_data_d;
  logic                  rd_valid_q;
  logic                  rd_oob_q;
  logic [DATA_WIDTH-1:0] rd_hold_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_rdata_q;
  logic                  mem_we;
  logic                  mem_re;
  logic [MEM_AW-1:0]     mem_waddr;
  logic [MEM_AW-1:0]     mem_raddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  rd_serve;
  logic [DATA_WIDTH-1:0] acc_raw;
  logic [DATA_WIDTH-1:0] acc_sum;

  assign wr_in_range = (write_req.addr >> MEM_AW) == '0;
  assign rd_in_range = (rd_addr >> MEM_AW) == '0;
  assign acc_raw     = mem_rdata_q + acc_data_q;

`ifdef MEMBANK_ACC_SATURATE_EN
  always_comb begin
    acc_sum = acc_raw;
    if ((mem_rdata_q[DATA_WIDTH-1] == acc_data_q[DATA_WIDTH-1]) &&
        (acc_raw[DATA_WIDTH-1] != mem_rdata_q[DATA_WIDTH-1])) begin
      acc_sum = mem_rdata_q[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    acc_sum = acc_raw;
  end
`endif

  // Reads win over writes in IDLE; ACC owns the array port for its write-back.
  always_comb begin
    state_d     = state_q;
    acc_addr_d  = acc_addr_q;
    acc_data_d  = acc_data_q;
    stall_front = 1'b1;
    rd_stall    = 1'b1;
    rd_serve    = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_waddr   = write_req.addr[MEM_AW-1:0];
    mem_raddr   = rd_addr[MEM_AW-1:0];
    mem_wdata   = write_req.data;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          rd_stall = 1'b0;
          if (rd_en) begin
            stall_front = write_req.en;
            rd_serve    = 1'b1;
            mem_re      = rd_in_range;
          end else begin
            stall_front = 1'b0;
            if (write_req.en && wr_in_range) begin
              if (write_req.forcewrite) begin
                mem_we = 1'b1;
              end else begin
                mem_re     = 1'b1;
                mem_raddr  = write_req.addr[MEM_AW-1:0];
                acc_addr_d = write_req.addr[MEM_AW-1:0];
                acc_data_d = write_req.data;
                state_d    = ACC;
              end
            end
          end
        end
        ACC: begin
          stall_front = write_req.en;
          rd_stall    = rd_en;
          mem_we      = 1'b1;
          mem_waddr   = acc_addr_q;
          mem_wdata   = acc_sum;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_addr_q <= '0;
      acc_data_q <= '0;
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_addr_q <= acc_addr_d;
      acc_data_q <= acc_data_d;
      rd_valid_q <= rd_serve;
      if (rd_serve) rd_oob_q <= !rd_in_range;
      if (rd_valid_q) rd_hold_q <= rd_data;
    end
  end

  // Array is deliberately not reset; the read register is shared by reads and accumulates.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata_q <= mem[mem_raddr];
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? (rd_oob_q ? '0 : mem_rdata_q) : rd_hold_q;

endmodule

// File: tb/tb_membank_write_ctrl.sv
// Directed self-checking bench for membank_write_ctrl (DATA_WIDTH=32, DEPTH=256).
// Honours MEMBANK_ACC_SATURATE_EN when choosing expected accumulate results.

module tb_membank_write_ctrl;
  import memory_pkg::*;

  logic                  clk;
  logic                  rst_n;
  write_req_pkt          write_req;
  logic                  stall_front;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_stall;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  membank_write_ctrl #(.DEPTH(256)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_req   (write_req),
    .stall_front (stall_front),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_stall    (rd_stall),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic force_wr(input logic [15:0] a, input logic [31:0] d, input string tag);
    write_req.en         = 1'b1;
    write_req.forcewrite = 1'b1;
    write_req.addr       = a;
    write_req.data       = d;
    rd_en                = 1'b0;
    smp();
    check_eq(tag, 32'(stall_front), 32'd0);
    cyc();
    write_req.en = 1'b0;
  endtask

  task automatic acc_wr(input logic [15:0] a, input logic [31:0] d, input string tag);
    write_req.en         = 1'b1;
    write_req.forcewrite = 1'b0;
    write_req.addr       = a;
    write_req.data       = d;
    rd_en                = 1'b0;
    smp();
    check_eq(tag, 32'(stall_front), 32'd0);
    cyc();
    write_req.en = 1'b0;
    cyc();
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string tag);
    rd_en   = 1'b1;
    rd_addr = a;
    smp();
    check_eq({tag, "_rd_stall"}, 32'(rd_stall), 32'd0);
    cyc();
    rd_en = 1'b0;
    smp();
    check_eq({tag, "_rd_valid"}, 32'(rd_valid), 32'd1);
    check_eq({tag, "_rd_data"}, rd_data, exp);
    cyc();
  endtask

  logic [31:0] exp_pos_ovf;
  logic [31:0] exp_neg_ovf;

  initial begin
`ifdef MEMBANK_ACC_SATURATE_EN
    exp_pos_ovf = 32'h7FFF_FFFF;
    exp_neg_ovf = 32'h8000_0000;
`else
    exp_pos_ovf = 32'h8000_0000;
    exp_neg_ovf = 32'h7FFF_FFFF;
`endif
    rst_n     = 1'b0;
    write_req = '0;
    write_req.en = 1'b1;
    rd_en     = 1'b1;
    rd_addr   = '0;
    #12;
    check_eq("rst_stall_front", 32'(stall_front), 32'd1);
    check_eq("rst_rd_stall", 32'(rd_stall), 32'd1);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_data", rd_data, 32'd0);
    write_req = '0;
    rd_en     = 1'b0;
    smp();
    rst_n = 1'b1;
    cyc();

    // forcewrite then read back
    force_wr(16'd5, 32'h1234, "fw5_stall");
    rd(16'd5, 32'h1234, "rd5");
    smp();
    check_eq("rd5_valid_drop", 32'(rd_valid), 32'd0);
    check_eq("rd5_data_hold", rd_data, 32'h1234);
    cyc();

    // back-to-back accumulates to one address
    force_wr(16'd7, 32'd10, "fw7_stall");
    write_req.en         = 1'b1;
    write_req.forcewrite = 1'b0;
    write_req.addr       = 16'd7;
    write_req.data       = 32'd3;
    smp();
    check_eq("b2b_stall0", 32'(stall_front), 32'd0);
    cyc();
    smp();
    check_eq("b2b_stall1", 32'(stall_front), 32'd1);
    cyc();
    smp();
    check_eq("b2b_stall2", 32'(stall_front), 32'd0);
    cyc();
    write_req.en = 1'b0;
    cyc();
    rd(16'd7, 32'd16, "rd7");

    // read and forcewrite in the same IDLE cycle
    force_wr(16'd20, 32'h55, "fw20a_stall");
    write_req.en         = 1'b1;
    write_req.forcewrite = 1'b1;
    write_req.addr       = 16'd20;
    write_req.data       = 32'hAA;
    rd_en                = 1'b1;
    rd_addr              = 16'd20;
    smp();
    check_eq("coll_stall_front", 32'(stall_front), 32'd1);
    check_eq("coll_rd_stall", 32'(rd_stall), 32'd0);
    cyc();
    rd_en = 1'b0;
    smp();
    check_eq("coll_wr_accept", 32'(stall_front), 32'd0);
    check_eq("coll_rd_valid", 32'(rd_valid), 32'd1);
    check_eq("coll_rd_old", rd_data, 32'h55);
    cyc();
    write_req.en = 1'b0;
    rd(16'd20, 32'hAA, "rd20");

    // read arriving during ACC
    force_wr(16'd30, 32'd100, "fw30_stall");
    write_req.en         = 1'b1;
    write_req.forcewrite = 1'b0;
    write_req.addr       = 16'd30;
    write_req.data       = 32'd5;
    smp();
    check_eq("acc30_stall", 32'(stall_front), 32'd0);
    cyc();
    write_req.en = 1'b0;
    rd_en        = 1'b1;
    rd_addr      = 16'd30;
    smp();
    check_eq("acc30_rd_stall", 32'(rd_stall), 32'd1);
    check_eq("acc30_front_idle", 32'(stall_front), 32'd0);
    cyc();
    smp();
    check_eq("acc30_rd_served", 32'(rd_stall), 32'd0);
    check_eq("acc30_no_valid_yet", 32'(rd_valid), 32'd0);
    cyc();
    rd_en = 1'b0;
    smp();
    check_eq("acc30_rd_valid", 32'(rd_valid), 32'd1);
    check_eq("acc30_rd_data", rd_data, 32'd105);
    cyc();

    // signed overflow in both directions
    force_wr(16'd9, 32'h7FFF_FFFF, "fw9_stall");
    acc_wr(16'd9, 32'd1, "acc9_stall");
    rd(16'd9, exp_pos_ovf, "rd9_ovf");
    force_wr(16'd10, 32'h8000_0000, "fw10_stall");
    acc_wr(16'd10, 32'hFFFF_FFFF, "acc10_stall");
    rd(16'd10, exp_neg_ovf, "rd10_ovf");

    // out-of-range writes dropped, out-of-range read returns zero
    force_wr(16'd44, 32'h44, "fw44_stall");
    force_wr(16'd300, 32'hDEAD, "fw300_stall");
    rd(16'd44, 32'h44, "rd44_alias");
    write_req.en         = 1'b1;
    write_req.forcewrite = 1'b0;
    write_req.addr       = 16'd300;
    write_req.data       = 32'd1;
    smp();
    check_eq("acc300_stall", 32'(stall_front), 32'd0);
    cyc();
    write_req.addr = 16'd44;
    smp();
    check_eq("acc300_no_acc", 32'(stall_front), 32'd0);
    cyc();
    write_req.en = 1'b0;
    cyc();
    rd(16'd300, 32'd0, "rd300");
    rd(16'd44, 32'h45, "rd44_acc");

    // reset during ACC abandons the pending write-back
    force_wr(16'd3, 32'd4, "fw3_stall");
    write_req.en         = 1'b1;
    write_req.forcewrite = 1'b0;
    write_req.addr       = 16'd3;
    write_req.data       = 32'd2;
    smp();
    check_eq("acc3_stall", 32'(stall_front), 32'd0);
    cyc();
    write_req.en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_acc_stall_front", 32'(stall_front), 32'd1);
    check_eq("rst_acc_rd_stall", 32'(rd_stall), 32'd1);
    check_eq("rst_acc_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_acc_rd_data", rd_data, 32'd0);
    cyc();
    #1;
    rst_n = 1'b1;
    cyc();
    rd(16'd3, 32'd4, "rd3_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
